// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

   localparam int unsigned ARB_N          = 32;
   localparam int unsigned ARB_STARVE_MAX = 4;

   // SaveMethod size encoding
   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_X = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_BUSY_I = 2'b01,
      ST_BUSY_D = 2'b10,
      ST_ERR_D  = 2'b11
   } arb_state_e;

   // Data accesses that can never reach memory: unaligned half/word or the illegal size code
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      return ((size == SIZE_H) && addr_lo[0]) ||
             ((size == SIZE_W) && (addr_lo != 2'b00)) ||
             (size == SIZE_X);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of data grants taken while a fetch was waiting.
module mem_port_arbiter_starve_counter #(
   parameter int unsigned MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_sat_c
);

   localparam int unsigned CW = $clog2(MAX + 1);

   logic [CW-1:0] r_cnt;
   logic          w_sat;

   assign w_sat   = (r_cnt == CW'(MAX));
   assign o_sat_c = w_sat;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !w_sat) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (I) and data access (D).
// D wins by default; a starvation counter forces an I grant. One access outstanding at a time.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned N          = ARB_N,
   parameter int unsigned STARVE_MAX = ARB_STARVE_MAX
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_req,
   input  logic [N-1:0] i_addr,
   output logic         i_rvalid,
   output logic [N-1:0] i_rdata,
   input  logic         d_req,
   input  logic         d_we,
   input  logic [1:0]   d_size,
   input  logic [N-1:0] d_addr,
   input  logic [N-1:0] d_wdata,
   output logic         d_rvalid,
   output logic [N-1:0] d_rdata,
   output logic         d_err,
   output logic         stall_if,
   output logic         stall_mem,
   output logic         mem_req,
   output logic         mem_we,
   output logic [1:0]   mem_size,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic         mem_rvalid,
   input  logic [N-1:0] mem_rdata
);

   arb_state_e r_state;
   arb_state_e w_state_nxt;
   logic       r_d_we;
   logic       w_mis;
   logic       w_sat;
   logic       w_grant_d;
   logic       w_grant_i;
   logic       w_unused;

   // Fetches are word aligned; the low address bits are dropped
   assign w_unused = ^i_addr[1:0];
   assign w_mis    = is_misaligned(d_size, d_addr[1:0]);

   mem_port_arbiter_starve_counter #(
      .MAX (STARVE_MAX)
   ) u_starve (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_grant_d & i_req),
      .i_clr   (w_grant_i),
      .o_sat_c (w_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_d_we  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant_d) begin
            r_d_we <= d_we;
         end
      end
   end

   // Grant, command and response muxing; everything held at zero during reset
   always_comb begin
      w_state_nxt = r_state;
      w_grant_d   = 1'b0;
      w_grant_i   = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_size    = SIZE_B;
      mem_addr    = '0;
      mem_wdata   = '0;
      i_rvalid    = 1'b0;
      i_rdata     = '0;
      d_rvalid    = 1'b0;
      d_rdata     = '0;
      d_err       = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_IDLE: begin
               if (d_req && w_mis) begin
                  w_state_nxt = ST_ERR_D;
               end else if (d_req && (!i_req || !w_sat)) begin
                  w_grant_d   = 1'b1;
                  mem_req     = 1'b1;
                  mem_we      = d_we;
                  mem_size    = d_size;
                  mem_addr    = d_addr;
                  mem_wdata   = d_wdata;
                  w_state_nxt = ST_BUSY_D;
               end else if (i_req) begin
                  w_grant_i   = 1'b1;
                  mem_req     = 1'b1;
                  mem_size    = SIZE_W;
                  mem_addr    = {i_addr[N-1:2], 2'b00};
                  w_state_nxt = ST_BUSY_I;
               end
            end
            ST_BUSY_I: begin
               if (mem_rvalid) begin
                  i_rvalid    = 1'b1;
                  i_rdata     = mem_rdata;
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_BUSY_D: begin
               if (mem_rvalid) begin
                  d_rvalid    = 1'b1;
                  d_rdata     = r_d_we ? '0 : mem_rdata;
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_ERR_D: begin
               d_rvalid    = 1'b1;
               d_err       = 1'b1;
               w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign stall_if  = !rst && i_req && !i_rvalid;
   assign stall_mem = !rst && d_req && !d_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, response scoreboard, corner sequences.
module tb_mem_port_arbiter;

   localparam int unsigned N = 32;

   logic         clk;
   logic         rst;
   logic         i_req;
   logic [N-1:0] i_addr;
   logic         i_rvalid;
   logic [N-1:0] i_rdata;
   logic         d_req;
   logic         d_we;
   logic [1:0]   d_size;
   logic [N-1:0] d_addr;
   logic [N-1:0] d_wdata;
   logic         d_rvalid;
   logic [N-1:0] d_rdata;
   logic         d_err;
   logic         stall_if;
   logic         stall_mem;
   logic         mem_req;
   logic         mem_we;
   logic [1:0]   mem_size;
   logic [N-1:0] mem_addr;
   logic [N-1:0] mem_wdata;
   logic         mem_rvalid;
   logic [N-1:0] mem_rdata;

   mem_port_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_rvalid   (i_rvalid),
      .i_rdata    (i_rdata),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_size     (d_size),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_rvalid   (d_rvalid),
      .d_rdata    (d_rdata),
      .d_err      (d_err),
      .stall_if   (stall_if),
      .stall_mem  (stall_mem),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_size   (mem_size),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Memory contents as seen by a read at byte address a
   function automatic logic [31:0] exp_word(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (w == 32'h0000_0010) return 32'h0050_0093;
      return w ^ 32'h5A5A_0000;
   endfunction

   // Memory model: answers each command after mem_lat cycles; stores return garbage data
   int          mem_lat = 1;
   int          m_cnt   = 0;
   logic [31:0] m_data  = 32'h0;
   initial begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
   end
   always @(posedge clk) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= 32'h0;
      if (m_cnt == 1) begin
         mem_rvalid <= 1'b1;
         mem_rdata  <= m_data;
      end
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
      if (mem_req && !rst) begin
         m_data <= mem_we ? 32'hDEAD_BEEF : exp_word(mem_addr);
         if (mem_lat <= 1) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= mem_we ? 32'hDEAD_BEEF : exp_word(mem_addr);
            m_cnt      <= 0;
         end else begin
            m_cnt <= mem_lat - 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        is_d;
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   rsp_t sb_q[$];
   logic got_i;
   logic got_d;

   task automatic sb_push(input logic is_d, input logic err, input logic [31:0] rdata);
      rsp_t r;
      r.is_d  = is_d;
      r.err   = err;
      r.rdata = rdata;
      sb_q.push_back(r);
   endtask

   // Pops one expected response per observed response pulse
   task automatic monitor();
      rsp_t e;
      got_i = 1'b0;
      got_d = 1'b0;
      if (i_rvalid || d_rvalid) begin
         got_i = i_rvalid;
         got_d = d_rvalid;
         if (sb_q.size() == 0) begin
            check("unexpected_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);
         end else begin
            e = sb_q.pop_front();
            check("rsp_port", 32'({i_rvalid, d_rvalid}), e.is_d ? 32'h1 : 32'h2);
            check("rsp_err", 32'(d_err), 32'(e.err));
            check("rsp_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
         end
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        i_req;
      logic [31:0] i_addr;
      logic        d_req;
      logic        d_we;
      logic [1:0]  d_size;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      int          lat;
      logic        e_req;
      logic        e_we;
      logic [1:0]  e_size;
      logic [31:0] e_addr;
      logic        e_isd;
      logic        e_err;
      logic [31:0] e_rdata;
   } vec_t;

   function automatic vec_t mk_d(input logic we, input logic [1:0] sz, input logic [31:0] a,
                                 input logic [31:0] wd, input int lat, input logic err);
      vec_t v;
      v.i_req = 1'b0;  v.i_addr = 32'h0;
      v.d_req = 1'b1;  v.d_we = we;  v.d_size = sz;  v.d_addr = a;  v.d_wdata = wd;
      v.lat   = lat;
      v.e_req = !err;  v.e_we = we;  v.e_size = sz;  v.e_addr = a;
      v.e_isd = 1'b1;  v.e_err = err;
      v.e_rdata = (err || we) ? 32'h0 : exp_word(a);
      return v;
   endfunction

   function automatic vec_t mk_i(input logic [31:0] a, input int lat, input logic [31:0] ea);
      vec_t v;
      v.i_req = 1'b1;  v.i_addr = a;
      v.d_req = 1'b0;  v.d_we = 1'b0;  v.d_size = 2'b00;  v.d_addr = 32'h0;  v.d_wdata = 32'h0;
      v.lat   = lat;
      v.e_req = 1'b1;  v.e_we = 1'b0;  v.e_size = 2'b10;  v.e_addr = ea;
      v.e_isd = 1'b0;  v.e_err = 1'b0;  v.e_rdata = exp_word(ea);
      return v;
   endfunction

   // One isolated transaction: command fields, scoreboarded response, stall duration
   task automatic run_txn(input vec_t v, input string tag);
      int   stall_n;
      logic done;
      mem_lat = v.lat;
      i_req   = v.i_req;  i_addr  = v.i_addr;
      d_req   = v.d_req;  d_we    = v.d_we;  d_size = v.d_size;
      d_addr  = v.d_addr; d_wdata = v.d_wdata;
      #1;
      check({tag, "_mem_req"}, 32'(mem_req), 32'(v.e_req));
      if (v.e_req) begin
         check({tag, "_mem_we"}, 32'(mem_we), 32'(v.e_we));
         check({tag, "_mem_size"}, 32'(mem_size), 32'(v.e_size));
         check({tag, "_mem_addr"}, mem_addr, v.e_addr);
         if (v.e_isd) check({tag, "_mem_wdata"}, mem_wdata, v.d_wdata);
      end
      sb_push(v.e_isd, v.e_err, v.e_rdata);
      stall_n = 0;
      done    = 1'b0;
      for (int k = 0; k < 30 && !done; k++) begin
         if (v.e_isd ? stall_mem : stall_if) stall_n++;
         cyc();
         if (sb_q.size() == 0) done = 1'b1;
      end
      i_req = 1'b0;
      d_req = 1'b0;
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: got no response, expected one within 30 cycles", tag);
         sb_q.delete();
      end
      check({tag, "_stall_cycles"}, 32'(stall_n), v.e_err ? 32'd1 : 32'(v.lat));
      cyc();
   endtask

   vec_t vecs[12];
   int   d_n;
   int   i_n;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk_i(32'h0000_0013, 3, 32'h0000_0010);
      vecs[1]  = mk_d(1'b0, 2'b10, 32'h0000_0100, 32'h0, 1, 1'b0);
      vecs[2]  = mk_d(1'b0, 2'b10, 32'h0000_0102, 32'h0, 1, 1'b1);
      vecs[3]  = mk_d(1'b1, 2'b01, 32'h0000_0204, 32'h0000_BEEF, 2, 1'b0);
      vecs[4]  = mk_d(1'b0, 2'b00, 32'h0000_0003, 32'h0, 1, 1'b0);
      vecs[5]  = mk_d(1'b0, 2'b01, 32'h0000_0205, 32'h0, 1, 1'b1);
      vecs[6]  = mk_d(1'b0, 2'b11, 32'h0000_0200, 32'h0, 1, 1'b1);
      vecs[7]  = mk_d(1'b0, 2'b01, 32'h0000_0206, 32'h0, 4, 1'b0);
      vecs[8]  = mk_i(32'h0000_2002, 2, 32'h0000_2000);
      vecs[9]  = mk_d(1'b1, 2'b10, 32'h0000_030C, 32'h1234_5678, 1, 1'b0);
      vecs[10] = mk_d(1'b0, 2'b10, 32'h0000_0101, 32'h0, 1, 1'b1);
      vecs[11] = mk_d(1'b1, 2'b00, 32'h0000_0207, 32'h0000_00AB, 1, 1'b0);

      // Reset held with both requests asserted
      rst = 1'b1;  i_req = 1'b1;  d_req = 1'b1;  d_we = 1'b0;
      d_size = 2'b10;  i_addr = 32'h40;  d_addr = 32'h100;  d_wdata = 32'h0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         check("rst_ctl", 32'({mem_req, mem_we, i_rvalid, d_rvalid, d_err, stall_if, stall_mem}), 32'h0);
         check("rst_data", mem_addr | mem_wdata | i_rdata | d_rdata | 32'(mem_size), 32'h0);
      end
      rst = 1'b0;  i_req = 1'b0;  d_req = 1'b0;
      #1;
      check("idle_after_rst", 32'({mem_req, i_rvalid, d_rvalid, d_err, stall_if, stall_mem}), 32'h0);
      cyc();

      for (int v = 0; v < 12; v++) run_txn(vecs[v], $sformatf("vec%0d", v));

      // Contention: D stream of 9 loads, I fetches twice; I forced through after every 4 D grants
      mem_lat = 1;
      for (int j = 0; j < 4; j++) sb_push(1'b1, 1'b0, exp_word(32'h100 + 32'(4 * j)));
      sb_push(1'b0, 1'b0, exp_word(32'h40));
      for (int j = 4; j < 8; j++) sb_push(1'b1, 1'b0, exp_word(32'h100 + 32'(4 * j)));
      sb_push(1'b0, 1'b0, exp_word(32'h44));
      sb_push(1'b1, 1'b0, exp_word(32'h120));
      d_we = 1'b0;  d_size = 2'b10;  d_addr = 32'h100;  i_addr = 32'h40;
      i_req = 1'b1;  d_req = 1'b1;
      d_n = 0;  i_n = 0;
      for (int k = 0; k < 80 && sb_q.size() != 0; k++) begin
         cyc();
         if (got_d) begin
            d_n++;
            d_addr = d_addr + 32'd4;
            if (d_n == 9) d_req = 1'b0;
         end
         if (got_i) begin
            i_n++;
            i_addr = i_addr + 32'd4;
            if (i_n == 2) i_req = 1'b0;
         end
      end
      i_req = 1'b0;  d_req = 1'b0;
      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL contention_timeout: got %0d pending responses, expected 0", sb_q.size());
         sb_q.delete();
      end
      cyc();

      // Reset during BUSY_D; the late memory completion must not produce a response
      mem_lat = 3;
      d_we = 1'b0;  d_size = 2'b10;  d_addr = 32'h300;  d_req = 1'b1;
      #1;
      check("stray_grant", 32'(mem_req), 32'h1);
      cyc();
      rst = 1'b1;  d_req = 1'b0;
      cyc();
      rst = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         check("stray_no_rsp", 32'({i_rvalid, d_rvalid, d_err}), 32'h0);
         check("stray_no_req", 32'(mem_req), 32'h0);
         cyc();
      end
      run_txn(mk_d(1'b0, 2'b10, 32'h0000_0304, 32'h0, 2, 1'b0), "after_stray");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
